// File: rtl/cpu_writeback.sv
// cpu_writeback: merges ALU and load results into an in-order register-file write queue
// Ports: clk/reset (async, active-high); alu_* and mem_* valid/ready write requests;
// flush drops queued writes; rd_* drive the register-file write port; rs1/rs2 hazard
// queries return *_pending; count/empty report queue occupancy.
module cpu_writeback #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [4:0]                 alu_rd,
    input  logic [XLEN-1:0]            alu_data,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [4:0]                 mem_rd,
    input  logic [XLEN-1:0]            mem_data,
    input  logic                       flush,
    output logic [4:0]                 rd_addr,
    output logic [XLEN-1:0]            rd_data,
    output logic                       rd_write_en,
    input  logic [4:0]                 rs1_addr,
    input  logic [4:0]                 rs2_addr,
    output logic                       rs1_pending,
    output logic                       rs2_pending,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [4:0]      rd_q   [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic [CW-1:0]   space;
    logic            alu_enq, mem_enq;
    logic [DEPTH-1:0] hit1, hit2;
    assign empty       = count == '0;
    assign rd_write_en = !empty && !flush;
    assign rd_addr     = rd_q[rptr];
    assign rd_data     = data_q[rptr];
    // the head retiring this cycle frees its slot for a same-cycle enqueue
    assign space     = CW'(DEPTH) - count + CW'(!empty);
    assign alu_ready = !flush && space >= CW'(1);
    assign mem_ready = !flush && space >= (alu_valid ? CW'(2) : CW'(1));
    // x0 writes handshake normally but never occupy a slot
    assign alu_enq = alu_valid && alu_ready && alu_rd != '0;
    assign mem_enq = mem_valid && mem_ready && mem_rd != '0;
    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        logic [AW-1:0] off;
        assign off     = AW'(g) - rptr;
        assign hit1[g] = ({1'b0, off} < count) && rd_q[g] == rs1_addr;
        assign hit2[g] = ({1'b0, off} < count) && rd_q[g] == rs2_addr;
    end
    assign rs1_pending = rs1_addr != '0 && |hit1;
    assign rs2_pending = rs2_addr != '0 && |hit2;
    always_ff @(posedge clk or posedge reset) begin
        if (reset || flush) begin
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
        end else begin
            count <= count + CW'(alu_enq) + CW'(mem_enq) - CW'(rd_write_en);
            rptr  <= rptr + AW'(rd_write_en);
            wptr  <= wptr + AW'(alu_enq) + AW'(mem_enq);
        end
    end
    // ALU entry lands ahead of the MEM entry when both are accepted together
    always_ff @(posedge clk) begin
        if (alu_enq) begin
            rd_q[wptr]   <= alu_rd;
            data_q[wptr] <= alu_data;
        end
        if (mem_enq) begin
            rd_q[wptr + AW'(alu_enq)]   <= mem_rd;
            data_q[wptr + AW'(alu_enq)] <= mem_data;
        end
    end
endmodule

// File: tb/tb_cpu_writeback.sv
// tb_cpu_writeback: scoreboard bench for cpu_writeback
module tb_cpu_writeback;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;
    logic clk = 0, reset = 1;
    logic alu_valid = 0, mem_valid = 0, flush = 0;
    logic [4:0] alu_rd = 0, mem_rd = 0, rs1_addr = 0, rs2_addr = 0;
    logic [XLEN-1:0] alu_data = 0, mem_data = 0;
    logic alu_ready, mem_ready, rd_write_en, rs1_pending, rs2_pending, empty;
    logic [4:0] rd_addr;
    logic [XLEN-1:0] rd_data;
    logic [$clog2(DEPTH):0] count;
    ent_t q[$];
    int errors = 0, checks = 0;

    cpu_writeback #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .flush(flush), .rd_addr(rd_addr), .rd_data(rd_data), .rd_write_en(rd_write_en),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic pend(input logic [4:0] a);
        if (a == 0) return 1'b0;
        foreach (q[i]) if (q[i].rd == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_idle_state(input string tag);
        check({tag, "_count"}, 64'(count), 64'(q.size()));
        check({tag, "_empty"}, 64'(empty), 64'(q.size() == 0));
        check({tag, "_we"}, 64'(rd_write_en), 64'(0));
        check({tag, "_alu_ready"}, 64'(alu_ready), 64'(1));
        check({tag, "_mem_ready"}, 64'(mem_ready), 64'(1));
        check({tag, "_rs1_pend"}, 64'(rs1_pending), 64'(0));
        check({tag, "_rs2_pend"}, 64'(rs2_pending), 64'(0));
    endtask

    // one cycle starting and ending at a falling edge; model updates at the rising edge
    task automatic cycle(input logic av, input logic [4:0] ard, input logic [XLEN-1:0] ad,
                         input logic mv, input logic [4:0] mrd, input logic [XLEN-1:0] md,
                         input logic fl);
        int n, space;
        logic exp_we, exp_ar, exp_mr;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        flush = fl;
        #1;
        n      = q.size();
        exp_we = n > 0 && !fl;
        space  = DEPTH - n + (n > 0 ? 1 : 0);
        exp_ar = !fl && space >= 1;
        exp_mr = !fl && space >= (av ? 2 : 1);
        check("count", 64'(count), 64'(n));
        check("empty", 64'(empty), 64'(n == 0));
        check("rd_write_en", 64'(rd_write_en), 64'(exp_we));
        check("alu_ready", 64'(alu_ready), 64'(exp_ar));
        check("mem_ready", 64'(mem_ready), 64'(exp_mr));
        check("rs1_pending", 64'(rs1_pending), 64'(pend(rs1_addr)));
        check("rs2_pending", 64'(rs2_pending), 64'(pend(rs2_addr)));
        if (exp_we) begin
            check("rd_addr", 64'(rd_addr), 64'(q[0].rd));
            check("rd_data", 64'(rd_data), 64'(q[0].data));
        end
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (exp_we) void'(q.pop_front());
            if (av && exp_ar && ard != 0) q.push_back('{ard, ad});
            if (mv && exp_mr && mrd != 0) q.push_back('{mrd, md});
        end
        @(negedge clk);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #1;
        check_idle_state("reset");
        @(negedge clk);
        reset = 0;
        // single write with hazard query
        rs1_addr = 5;
        cycle(1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
        idle(2);
        // dual accept, ALU ahead of MEM
        rs1_addr = 1; rs2_addr = 2;
        cycle(1, 1, 32'h11, 1, 2, 32'h22, 0);
        idle(3);
        // x0 requests are accepted but dropped
        cycle(1, 0, 32'h55, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 32'h66, 0);
        idle(1);
        // fill three entries then flush
        rs1_addr = 6; rs2_addr = 7;
        cycle(1, 3, 32'h33, 1, 4, 32'h44, 0);
        cycle(1, 6, 32'h66, 1, 7, 32'h77, 0);
        cycle(0, 0, 0, 0, 0, 0, 1);
        idle(2);
        // backpressure: both ports valid every cycle
        for (int i = 0; i < 20; i++)
            cycle(1, 5'($urandom_range(1, 31)), $urandom, 1, 5'($urandom_range(1, 31)), $urandom, 0);
        idle(6);
        // random mix with occasional flush and x0 targets
        for (int i = 0; i < 300; i++) begin
            rs1_addr = 5'($urandom_range(0, 7));
            rs2_addr = 5'($urandom_range(0, 7));
            cycle(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 15) == 0);
        end
        idle(6);
        // reset asserted between edges with three entries queued
        rs1_addr = 9; rs2_addr = 10;
        cycle(1, 8, 32'h88, 1, 9, 32'h99, 0);
        cycle(1, 10, 32'hAA, 1, 11, 32'hBB, 0);
        check("pre_reset_count", 64'(count), 64'(3));
        #2 reset = 1;
        q.delete();
        #1;
        check_idle_state("midreset");
        #1 reset = 0;
        idle(3);
        cycle(1, 12, 32'hCC, 0, 0, 0, 0);
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cpu_writeback.md
CPU_WRITEBACK -- requirements
Module: cpu_writeback

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width (32 or 64).
REQ-002 SHALL have parameter DEPTH, default 4, write-queue entries (power of two, >= 2).
REQ-003 SHALL have one clock and an asynchronous, active-high reset, ports as listed below.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU write request
- alu_ready  out  1  ALU request accepted this cycle when high with alu_valid
- alu_rd  in  5  ALU destination register
- alu_data  in  XLEN  ALU result
- mem_valid  in  1  load-unit write request
- mem_ready  out  1  load request accepted this cycle when high with mem_valid
- mem_rd  in  5  load destination register
- mem_data  in  XLEN  load result
- flush  in  1  discard all queued writes
- rd_addr  out  5  register-file write address
- rd_data  out  XLEN  register-file write data
- rd_write_en  out  1  register-file write strobe
- rs1_addr  in  5  hazard query, source 1
- rs2_addr  in  5  hazard query, source 2
- rs1_pending  out  1  queued write targets rs1_addr
- rs2_pending  out  1  queued write targets rs2_addr
- count  out  $clog2(DEPTH)+1  queued entries
- empty  out  1  count == 0

Function
REQ-004 SHALL hold writes in a FIFO of DEPTH entries {rd, data}; head drives rd_addr/rd_data combinationally.
REQ-005 SHALL assert rd_write_en = !empty && !flush; the head pops on every rising edge where rd_write_en is high.
REQ-006 SHALL compute space = DEPTH - count + (empty ? 0 : 1).
REQ-007 SHALL drive alu_ready = !flush && space >= 1.
REQ-008 SHALL drive mem_ready = !flush && space >= (alu_valid ? 2 : 1).
REQ-009 SHALL, on handshake, enqueue at the same edge; when both handshake in one cycle, ALU entry SHALL be enqueued ahead of MEM entry.
REQ-010 SHALL accept requests with rd == 0 under the same ready rules but SHALL NOT enqueue them (no count change, no rd_write_en).
REQ-011 SHALL give latency of exactly one cycle from accept edge to rd_write_en when the queue was empty, i.e. regfile written at the following edge.
REQ-012 SHALL support simultaneous enqueue (up to 2) and pop in one cycle; count(next) = count + enqueued - popped.
REQ-013 SHALL on flush high: suppress rd_write_en, accept nothing, and set count to 0 at that edge.
REQ-014 SHALL drive rsN_pending = 1 iff rsN_addr != 0 and any valid queue entry (head included) has rd == rsN_addr; combinational, not affected by same-cycle enqueues.
REQ-015 SHALL never overflow: count <= DEPTH at all times; read/write pointers SHALL wrap modulo DEPTH.
REQ-016 SHALL treat a request dropped by the source (valid low before ready) as not accepted; no state change.

Reset
REQ-017 SHALL on reset assertion immediately clear count and pointers: count=0, empty=1, rd_write_en=0, rs1_pending=rs2_pending=0, alu_ready=mem_ready=1 (flush low).
REQ-018 SHALL discard any queued or in-flight write when reset asserts mid-operation; no write strobe after release until a new accept.
REQ-019 SHALL resume normal acceptance on the first rising edge after reset deasserts.

Verification
REQ-020 Single write: alu_valid, alu_rd=5, alu_data=0xDEADBEEF for 1 cycle -> next cycle rd_write_en=1, rd_addr=5, rd_data=0xDEADBEEF, rs1_pending=1 for rs1_addr=5; cycle after empty=1.
REQ-021 Dual accept: alu rd=1 data=0x11, mem rd=2 data=0x22 same cycle, queue empty -> writes x1=0x11 then x2=0x22 on consecutive cycles; count peaks at 2.
REQ-022 Backpressure: DEPTH=4, both ports valid every cycle with rd != 0 -> count saturates at 4, mem_ready=0 whenever space < 2, no entry lost or reordered across 20 cycles.
REQ-023 x0 drop: alu_rd=0 data=0x55 -> alu_ready=1, count stays 0, rd_write_en never asserts.
REQ-024 Flush: fill 3 entries, assert flush 1 cycle -> rd_write_en=0 that cycle, count=0 next cycle, pending flags clear, no queued write reaches regfile.
REQ-025 Reset mid-operation: 3 entries queued, pulse reset between edges -> count=0 and rd_write_en=0 immediately, no strobe until a new accept after release.
